// File: rtl/fetch_buffer_if.sv
// Fetch/decode handshake bundle for the instruction prefetch buffer.
// The master modport is the PC/imem/decode side; the slave modport is the buffer itself.
interface fetch_buffer_if #(
  parameter int PTR_W = 2
);
  logic             start_i;
  logic [31:0]      pc_i;
  logic [31:0]      instr_i;
  logic             fetch_valid_i;
  logic             fetch_ready_o;
  logic             id_stall_i;
  logic             flush_i;
  logic [31:0]      instr_o;
  logic [31:0]      pc_o;
  logic             valid_o;
  logic [PTR_W:0]   count_o;

  modport master (
    output start_i, pc_i, instr_i, fetch_valid_i, id_stall_i, flush_i,
    input  fetch_ready_o, instr_o, pc_o, valid_o, count_o
  );

  modport slave (
    input  start_i, pc_i, instr_i, fetch_valid_i, id_stall_i, flush_i,
    output fetch_ready_o, instr_o, pc_o, valid_o, count_o
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction prefetch FIFO between fetch and the IF/ID boundary; flush empties it
// in one edge and the outputs read as a nop whenever nothing is queued.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  fetch_buffer_if.slave bus
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [63:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;

  logic             full_s;
  logic             valid_s;
  logic             ready_s;
  logic             push_s;
  logic             pop_s;
  logic [PTR_W:0]   count_nxt_s;
  logic [63:0]      head_s;

  // Handshake decode: space is judged on the registered count, so a same-cycle pop never frees a slot.
  always_comb begin
    full_s  = (count_r == FULL_COUNT);
    valid_s = (count_r != {(PTR_W + 1){1'b0}});
    ready_s = bus.start_i & ~bus.flush_i & ~full_s;
    push_s  = bus.fetch_valid_i & ready_s;
    pop_s   = bus.start_i & valid_s & ~bus.id_stall_i & ~bus.flush_i;
  end

  // Occupancy update for the next edge; simultaneous push and pop cancel out.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + (PTR_W + 1)'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - (PTR_W + 1)'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointer and count registers; flush beats both push and pop.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else if (bus.flush_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Entry storage is deliberately left unreset; empty slots are masked at the outputs.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {bus.pc_i, bus.instr_i};
    end
  end

  // Head-of-queue presentation, forced to a nop when empty.
  always_comb begin
    if (valid_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = 64'h0;
    end
  end

  assign bus.fetch_ready_o = ready_s;
  assign bus.valid_o       = valid_s;
  assign bus.pc_o          = head_s[63:32];
  assign bus.instr_o       = head_s[31:0];
  assign bus.count_o       = count_r;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and randomized bench for fetch_buffer, checked against a queue model of the FIFO.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  int   tests = 0;
  int   fails = 0;
  logic [63:0] model_q[$];
  logic [31:0] exp_pc [6];

  always #5 clk_i = ~clk_i;

  fetch_buffer_if #(.PTR_W(PTR_W)) bus ();

  fetch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_ready;
    e_ready = bus.start_i & ~bus.flush_i & (model_q.size() != DEPTH);
    e_pc    = (model_q.size() != 0) ? model_q[0][63:32] : 32'h0;
    e_instr = (model_q.size() != 0) ? model_q[0][31:0]  : 32'h0;
    check({tag, ".count"}, 32'(bus.count_o), 32'(model_q.size()));
    check({tag, ".valid"}, 32'(bus.valid_o), 32'(model_q.size() != 0));
    check({tag, ".pc"},    bus.pc_o,    e_pc);
    check({tag, ".instr"}, bus.instr_o, e_instr);
    check({tag, ".ready"}, 32'(bus.fetch_ready_o), 32'(e_ready));
  endtask

  // Drive inputs at the falling edge, then compare the settled outputs with the model.
  task automatic drive(input logic st, input logic fv, input logic [31:0] pc,
                       input logic [31:0] instr, input logic stall, input logic fl,
                       input string tag);
    bus.start_i       = st;
    bus.fetch_valid_i = fv;
    bus.pc_i          = pc;
    bus.instr_i       = instr;
    bus.id_stall_i    = stall;
    bus.flush_i       = fl;
    #1;
    check_model(tag);
  endtask

  // Advance one clock, applying the FIFO rules to the model at the rising edge.
  task automatic clock_edge();
    logic ready;
    logic push;
    logic pop;
    @(posedge clk_i);
    ready = bus.start_i & ~bus.flush_i & (model_q.size() != DEPTH);
    push  = bus.fetch_valid_i & ready;
    pop   = bus.start_i & (model_q.size() != 0) & ~bus.id_stall_i & ~bus.flush_i;
    if (bus.flush_i) begin
      model_q.delete();
    end else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back({bus.pc_i, bus.instr_i});
    end
    @(negedge clk_i);
  endtask

  task automatic step(input logic st, input logic fv, input logic [31:0] pc,
                      input logic stall, input logic fl, input string tag);
    drive(st, fv, pc, pc + 32'h100, stall, fl, tag);
    clock_edge();
  endtask

  initial begin
    rst_i             = 1'b0;
    bus.start_i       = 1'b0;
    bus.fetch_valid_i = 1'b0;
    bus.pc_i          = 32'h0;
    bus.instr_i       = 32'h0;
    bus.id_stall_i    = 1'b0;
    bus.flush_i       = 1'b0;
    #1;
    check("rst.count", 32'(bus.count_o), 32'h0);
    check("rst.valid", 32'(bus.valid_o), 32'h0);
    check("rst.pc",    bus.pc_o,    32'h0);
    check("rst.instr", bus.instr_o, 32'h0);
    check("rst.ready_idle", 32'(bus.fetch_ready_o), 32'h0);
    bus.start_i = 1'b1;
    #1;
    check("rst.ready_run", 32'(bus.fetch_ready_o), 32'h1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Streaming: one push and one pop per cycle after the first.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 32'(4 * i), 32'(4 * i) + 32'h100, 1'b0, 1'b0, "stream");
      if (i > 0) begin
        check("stream.pc_seq", bus.pc_o, 32'(4 * (i - 1)));
        check("stream.cnt1", 32'(bus.count_o), 32'h1);
      end
      clock_edge();
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "drain");

    // Fill under stall; the fifth fetch is refused.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 32'(4 * i), 1'b1, 1'b0, "fill");
    end
    drive(1'b1, 1'b1, 32'h10, 32'h110, 1'b0, 1'b0, "full_pop");
    check("full.count", 32'(bus.count_o), 32'h4);
    check("full.ready", 32'(bus.fetch_ready_o), 32'h0);
    check("full.pc",    bus.pc_o, 32'h0);
    clock_edge();

    // Drain across the pointer wrap while pushing.
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 32'h10 + 32'(4 * i), 32'h110 + 32'(4 * i), 1'b0, 1'b0, "wrap");
      check("wrap.pc_seq", bus.pc_o, exp_pc[i]);
      check("wrap.cnt3", 32'(bus.count_o), 32'h3);
      clock_edge();
    end

    // Flush with three entries queued.
    drive(1'b1, 1'b1, 32'h40, 32'h140, 1'b0, 1'b1, "flush");
    check("flush.ready", 32'(bus.fetch_ready_o), 32'h0);
    check("flush.cnt_before", 32'(bus.count_o), 32'h3);
    clock_edge();
    drive(1'b1, 1'b1, 32'h40, 32'h140, 1'b0, 1'b0, "post_flush");
    check("post_flush.count", 32'(bus.count_o), 32'h0);
    check("post_flush.valid", 32'(bus.valid_o), 32'h0);
    check("post_flush.instr", bus.instr_o, 32'h0);
    clock_edge();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "after_flush");
    check("after_flush.pc", bus.pc_o, 32'h40);
    clock_edge();

    // Asynchronous reset between edges with two entries queued.
    step(1'b1, 1'b1, 32'h50, 1'b1, 1'b0, "pre_rst");
    step(1'b1, 1'b1, 32'h54, 1'b1, 1'b0, "pre_rst");
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "pre_rst_idle");
    check("pre_rst.count", 32'(bus.count_o), 32'h2);
    #1 rst_i = 1'b0;
    #1;
    check("arst.count", 32'(bus.count_o), 32'h0);
    check("arst.valid", 32'(bus.valid_o), 32'h0);
    check("arst.pc",    bus.pc_o, 32'h0);
    model_q.delete();
    #1 rst_i = 1'b1;
    @(negedge clk_i);

    // Randomized traffic with occasional flushes and run-enable drops.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), 1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 11) == 0), "rand");
      clock_edge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
